mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences the shared PC, IR, ALU, immediate extender, data memory and register file through IF/ID/EX/MEM/WB states.
- Selects the extender mode (zero, sign, upper) for each instruction.
- Waits on instruction/data memory ready handshakes, so memory latency is tolerated.

Parameters:
- IM_WAIT_MAX, 15, maximum IF cycles waiting for im_ready before the timeout flag is raised; 4-bit counter.
- DM_WAIT_MAX, 15, same limit for data memory in MEM.

Ports:
- clk input 1 system clock, rising edge.
- rst_n input 1 asynchronous active-low reset.
- opcode input 6 IR[31:26], stable from ID onward.
- funct input 6 IR[5:0].
- zero input 1 ALU equal flag, valid in EX.
- im_ready input 1 instruction memory data valid.
- dm_ready input 1 data memory access complete.
- pc_wr output 1 PC write enable.
- ir_wr output 1 IR write enable.
- reg_wr output 1 register file write enable.
- mem_wr output 1 data memory write request.
- mem_rd output 1 data memory read request.
- ext_op output 2 extender mode: 0 zero-extend, 1 sign-extend, 2 imm<<16.
- alu_src output 1 ALU B operand: 0 rt, 1 extended immediate.
- alu_op output 3 ALU function: 0 add, 1 sub, 2 or, 3 pass B.
- reg_dst output 2 write register select: 0 rt, 1 rd, 2 $31.
- mem_to_reg output 2 write data select: 0 ALU, 1 memory, 2 PC.
- pc_src output 2 next-PC select: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
- state output 3 current state, for debug.
- illegal output 1 one-cycle pulse on an unsupported instruction.
- timeout output 1 sticky flag: a wait limit was exceeded.

Behaviour:
- Reset (async, rst_n=0):
  - state=IF(0); wait counter=0; timeout=0; illegal=0.
  - All write enables and requests are forced 0 while rst_n=0, regardless of state.
  - Release is sampled at the next rising edge.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5-7 go to IF on the next edge with no enables asserted.
- Outputs are combinational from state, opcode and funct (Moore style plus decode). Any output not listed for a state is 0.
- IF:
  - ir_wr=im_ready, pc_wr=im_ready, pc_src=0.
  - im_ready=1: go to ID. Otherwise stay in IF and increment the wait counter.
  - Counter reaching IM_WAIT_MAX sets timeout. The FSM keeps waiting; there is no abort.
- ID:
  - Decode. Supported: addu (0/0x21), subu (0/0x23), jr (0/0x08), ori (0x0d), lui (0x0f), lw (0x23), sw (0x2b), beq (0x04), jal (0x03).
  - nop (0/0x00) is treated as sll and treated as illegal.
  - jal: pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Go to IF.
  - jr: pc_wr=1, pc_src=3. Go to IF.
  - Unsupported opcode/funct: illegal=1 for this cycle. Go to IF; the instruction becomes a nop.
  - All others: go to EX.
- EX:
  - addu: alu_op=0, alu_src=0.
  - subu: alu_op=1, alu_src=0.
  - ori: alu_op=2, alu_src=1, ext_op=0.
  - lui: alu_op=3, alu_src=1, ext_op=2.
  - lw/sw: alu_op=0, alu_src=1, ext_op=1.
  - beq: alu_op=1, ext_op=1, pc_src=1, pc_wr=zero. Go to IF.
  - R-type/ori/lui: go to WB. lw/sw: go to MEM.
  - ext_op, alu_src and alu_op are held stable through MEM and WB for the same instruction.
- MEM:
  - lw: mem_rd=1. sw: mem_wr=1.
  - Requests are held until dm_ready=1, then lw goes to WB and sw goes to IF.
  - The wait counter and timeout behave as in IF, using DM_WAIT_MAX.
  - mem_wr and dm_ready both high in the same cycle completes the store once.
- WB:
  - reg_wr=1.
  - reg_dst: 1 for R-type, 0 for ori/lui/lw.
  - mem_to_reg: 1 for lw, 0 otherwise.
  - Go to IF.
- The wait counter clears on every state change. It saturates at 15 and does not wrap.
- CPI: R/ori/lui 4, lw 5, sw 4, beq 3, jal/jr 2, each plus memory wait cycles.
- Reset asserted mid-instruction: the FSM returns to IF immediately; a pending write is dropped.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- When defined, adds output ports cycle_cnt[31:0] and instr_cnt[31:0]:
  - Both reset to 0.
  - cycle_cnt increments every clock after reset.
  - instr_cnt increments on each transition into IF from ID, EX, MEM or WB, including illegal instructions.
  - Both wrap at 2^32.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then im_ready=1 constantly, addu (funct 0x21) → states 0,1,2,4,0; reg_wr=1, reg_dst=1 only in the WB cycle; pc_wr=1 in IF only.
- ori (0x0d) then lui (0x0f) → ext_op=0 and alu_op=2 in EX for ori; ext_op=2 and alu_op=3 in EX for lui; both write back with reg_dst=0.
- lw with dm_ready delayed 3 cycles → MEM lasts 4 cycles with mem_rd=1, then WB with mem_to_reg=1; total 8 cycles.
- beq: zero=1 gives pc_wr=1, pc_src=1, ext_op=1 in EX; zero=0 gives pc_wr=0 in EX; both return to IF after 3 cycles.
- jal (0x03) → in ID, pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, mem_to_reg=2; next state IF.
- Opcode 0x3f → illegal pulses 1 cycle in ID, no enables asserted. Separately, im_ready held 0 for 16 cycles sets timeout=1; rst_n low mid-MEM gives state=0 and mem_wr=0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle main controller and the MIPS datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       im_ready;
    logic       dm_ready;

    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic [1:0] ext_op;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic       illegal;
    logic       timeout;

    modport master (
        input  opcode, funct, zero, im_ready, dm_ready,
        output pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, ext_op, alu_src, alu_op,
               reg_dst, mem_to_reg, pc_src, state, illegal, timeout
    );

    modport slave (
        output opcode, funct, zero, im_ready, dm_ready,
        input  pc_wr, ir_wr, reg_wr, mem_wr, mem_rd, ext_op, alu_src, alu_op,
               reg_dst, mem_to_reg, pc_src, state, illegal, timeout
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: IF/ID/EX/MEM/WB sequencing with memory ready handshakes.
// Defining MC_CTRL_PERF_EN adds the cycle_cnt / instr_cnt performance counter ports.
module mc_ctrl #(
    parameter logic [3:0] IM_WAIT_MAX = 4'd15,
    parameter logic [3:0] DM_WAIT_MAX = 4'd15
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } stateE;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_ILL
    } instrE;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_PASSB = 3'd3;

    stateE      stateQ, stateNext;
    instrE      instr;
    logic [3:0] waitCnt, waitCntNext;
    logic [3:0] waitLimit;
    logic       timeoutQ, setTimeout;
    logic [1:0] exExtOp;
    logic       exAluSrc;
    logic [2:0] exAluOp;

    // Instruction decode; sll (nop) and every other unlisted encoding fall to I_ILL.
    always_comb begin
        instr = I_ILL;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
                    FN_JR:   instr = I_JR;
                    default: instr = I_ILL;
                endcase
            end
            OP_JAL:  instr = I_JAL;
            OP_BEQ:  instr = I_BEQ;
            OP_ORI:  instr = I_ORI;
            OP_LUI:  instr = I_LUI;
            OP_LW:   instr = I_LW;
            OP_SW:   instr = I_SW;
            default: instr = I_ILL;
        endcase
    end

    // ALU/extender setup is a function of the instruction only, so it holds from EX through WB.
    always_comb begin
        exExtOp  = EXT_ZERO;
        exAluSrc = 1'b0;
        exAluOp  = ALU_ADD;
        case (instr)
            I_ADDU: exAluOp = ALU_ADD;
            I_SUBU: exAluOp = ALU_SUB;
            I_ORI: begin
                exAluOp  = ALU_OR;
                exAluSrc = 1'b1;
                exExtOp  = EXT_ZERO;
            end
            I_LUI: begin
                exAluOp  = ALU_PASSB;
                exAluSrc = 1'b1;
                exExtOp  = EXT_UPPER;
            end
            I_LW, I_SW: begin
                exAluOp  = ALU_ADD;
                exAluSrc = 1'b1;
                exExtOp  = EXT_SIGN;
            end
            I_BEQ: begin
                exAluOp = ALU_SUB;
                exExtOp = EXT_SIGN;
            end
            default: ;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext      = ST_IF;
        bus.pc_wr      = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.ext_op     = EXT_ZERO;
        bus.alu_src    = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 2'd0;
        bus.pc_src     = 2'd0;
        bus.illegal    = 1'b0;

        case (stateQ)
            ST_IF: begin
                bus.ir_wr = bus.im_ready;
                bus.pc_wr = bus.im_ready;
                stateNext = bus.im_ready ? ST_ID : ST_IF;
            end
            ST_ID: begin
                stateNext = ST_EX;
                case (instr)
                    I_JAL: begin
                        // PC already holds PC+4, which is the link value for $31.
                        bus.pc_wr      = 1'b1;
                        bus.pc_src     = 2'd2;
                        bus.reg_wr     = 1'b1;
                        bus.reg_dst    = 2'd2;
                        bus.mem_to_reg = 2'd2;
                        stateNext      = ST_IF;
                    end
                    I_JR: begin
                        bus.pc_wr  = 1'b1;
                        bus.pc_src = 2'd3;
                        stateNext  = ST_IF;
                    end
                    I_ILL: begin
                        bus.illegal = 1'b1;
                        stateNext   = ST_IF;
                    end
                    default: stateNext = ST_EX;
                endcase
            end
            ST_EX: begin
                bus.ext_op  = exExtOp;
                bus.alu_src = exAluSrc;
                bus.alu_op  = exAluOp;
                case (instr)
                    I_BEQ: begin
                        bus.pc_src = 2'd1;
                        bus.pc_wr  = bus.zero;
                        stateNext  = ST_IF;
                    end
                    I_LW, I_SW: stateNext = ST_MEM;
                    I_ADDU, I_SUBU, I_ORI, I_LUI: stateNext = ST_WB;
                    default: stateNext = ST_IF;
                endcase
            end
            ST_MEM: begin
                bus.ext_op  = exExtOp;
                bus.alu_src = exAluSrc;
                bus.alu_op  = exAluOp;
                bus.mem_rd  = (instr == I_LW);
                bus.mem_wr  = (instr == I_SW);
                if (instr == I_LW)
                    stateNext = bus.dm_ready ? ST_WB : ST_MEM;
                else if (instr == I_SW)
                    stateNext = bus.dm_ready ? ST_IF : ST_MEM;
                else
                    stateNext = ST_IF;
            end
            ST_WB: begin
                bus.ext_op     = exExtOp;
                bus.alu_src    = exAluSrc;
                bus.alu_op     = exAluOp;
                bus.reg_wr     = 1'b1;
                bus.reg_dst    = (instr == I_ADDU || instr == I_SUBU) ? 2'd1 : 2'd0;
                bus.mem_to_reg = (instr == I_LW) ? 2'd1 : 2'd0;
                stateNext      = ST_IF;
            end
            default: stateNext = ST_IF;
        endcase

        // NOTE: the state register already resets asynchronously, but IF still decodes
        // im_ready; gating here keeps every strobe low for the whole time rst_n is low.
        if (!rst_n) begin
            bus.pc_wr   = 1'b0;
            bus.ir_wr   = 1'b0;
            bus.reg_wr  = 1'b0;
            bus.mem_wr  = 1'b0;
            bus.mem_rd  = 1'b0;
            bus.illegal = 1'b0;
        end
    end

    // Wait counter: clears on any state change, saturates at 15 while a state waits.
    always_comb begin
        waitLimit   = (stateQ == ST_MEM) ? DM_WAIT_MAX : IM_WAIT_MAX;
        waitCntNext = 4'd0;
        setTimeout  = 1'b0;
        if (stateNext == stateQ) begin
            waitCntNext = (waitCnt == 4'hf) ? waitCnt : waitCnt + 4'd1;
            setTimeout  = (waitCntNext >= waitLimit);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= ST_IF;
            waitCnt  <= 4'd0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateNext;
            waitCnt  <= waitCntNext;
            timeoutQ <= timeoutQ | setTimeout;
        end
    end

    assign bus.state   = stateQ;
    assign bus.timeout = timeoutQ;

`ifdef MC_CTRL_PERF_EN
    logic retire;

    assign retire = (stateNext == ST_IF) &&
                    (stateQ inside {ST_ID, ST_EX, ST_MEM, ST_WB});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
